lsu_mem_if: RTL and testbench
=============================

Name: lsu_mem_if

Overview:
Load/store unit that drives the data-memory bus and produces the load data consumed by the writeback stage.
- Accepts one load or store per request from the execute stage.
- Generates word-aligned bus transactions with byte enables over a req/gnt/rvalid handshake.
- Aligns and sign/zero-extends load data, and stalls the pipeline while a transaction is outstanding.

Parameters:
TIMEOUT, 255, max cycles in WAIT before the transaction is abandoned with err_o
CNT_W, $clog2(TIMEOUT+1), timeout counter width (derived; do not override)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
req_valid_i  in  1  execute stage presents a memory operation
req_we_i  in  1  1=store, 0=load
req_funct3_i  in  3  RV32I size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr_i  in  32  byte address (ALU result)
req_wdata_i  in  32  store data (rs2)
req_ready_o  out  1  high only in IDLE
stall_o  out  1  freeze upstream pipeline
mem_req_o  out  1  bus request
mem_we_o  out  1  bus write
mem_addr_o  out  32  word address, bits [1:0] always 00
mem_be_o  out  4  byte enables
mem_wdata_o  out  32  lane-replicated store data
mem_gnt_i  in  1  bus accepts request
mem_rvalid_i  in  1  bus response (load data or store ack)
mem_rdata_i  in  32  bus read data
mem_o  out  32  extended load result to writeback
done_o  out  1  one-cycle pulse on completion
misalign_o  out  1  one-cycle pulse, misaligned access rejected
err_o  out  1  one-cycle pulse, illegal funct3 or timeout

Behaviour:
- States: IDLE, REQ, WAIT. Reset (async) forces IDLE immediately.
  - mem_req_o, done_o, misalign_o, err_o = 0.
  - mem_o = 0.
  - All captured request registers and the timeout counter = 0.
- IDLE, on req_valid_i:
  - off = req_addr_i[1:0]; misaligned = (H/HU and off[0]) or (W and off!=0).
  - Illegal = load funct3 in {011,110,111}, or store funct3 not in {000,001,010}.
  - Illegal or misaligned: next cycle err_o/misalign_o pulses; no bus access; stay IDLE. Illegal takes priority over misaligned.
  - Otherwise: register we, funct3, off, mem_addr_o={addr[31:2],00}, mem_be_o and mem_wdata_o; go to REQ.
- Byte enables / store data:
  - B: be=0001<<off, wdata={4{wdata[7:0]}}.
  - H: be=0011<<off, wdata={2{wdata[15:0]}}.
  - W: be=1111, wdata=wdata.
  - For loads, mem_be_o uses the same size rule; mem_wdata_o is don't-care (drive 0).
- REQ:
  - mem_req_o=1; addr/be/wdata/we held stable until mem_gnt_i.
  - On gnt go to WAIT and clear the timeout counter.
  - mem_rvalid_i is ignored in REQ.
- WAIT:
  - mem_req_o=0; the counter increments each cycle.
  - On mem_rvalid_i:
    - Load: mem_o <= extracted lane, sign-extended for B/H and zero-extended for BU/HU. Lane = rdata>>(8*off).
    - Store: mem_o unchanged.
    - In both cases done_o pulses the next cycle and the state returns to IDLE.
  - If the counter reaches TIMEOUT without rvalid: err_o pulses, mem_o unchanged, return to IDLE. A late rvalid arriving in IDLE is ignored.
  - rvalid in the same cycle the counter reaches TIMEOUT: the response wins (done_o, not err_o).
- Handshake and stall:
  - req_ready_o = (state==IDLE).
  - stall_o = (state!=IDLE) or (IDLE and req_valid_i and not illegal and not misaligned). Combinational.
  - Upstream holds req_* stable while stall_o=1.
  - done_o and the next accepted request may coincide: the request in the done_o cycle is accepted normally. Back-to-back throughput is one operation per 3 cycles minimum.
- mem_o holds its value between loads; writeback samples it in the done_o cycle or later.
- Reset mid-transaction abandons the bus request immediately; the responder must tolerate the withdrawn mem_req_o.

Test Plan:
- LB at addr 0x1003, rdata=0x80FF_FF7F, gnt in REQ cycle, rvalid 1 cycle later -> be=1000, mem_addr_o=0x1000, mem_o=0xFFFF_FF80, done_o one pulse, stall_o high for exactly REQ+WAIT+accept cycles.
- LHU at 0x2002, rdata=0xBEEF_1234 -> be=1100, mem_o=0x0000_BEEF; then LH same data -> mem_o=0xFFFF_BEEF.
- SH at 0x3002, wdata=0x1234_ABCD, gnt delayed 3 cycles -> mem_we_o=1, be=1100, mem_wdata_o=0xABCD_ABCD held stable all 4 REQ cycles, mem_o unchanged after ack.
- LW at 0x4001 -> misalign_o pulses once, mem_req_o never asserted, stays IDLE; funct3=011 load -> err_o pulse, no bus access.
- LW granted, no rvalid for TIMEOUT=4 (override) -> err_o after 4 WAIT cycles, IDLE; rvalid on the 4th cycle instead -> done_o, no err_o.
- rst asserted mid-REQ (asynchronously, between edges) -> mem_req_o drops without a clock edge, mem_o=0, req_ready_o=1 after release.

Source files
------------

// File: rtl/lsu_mem_if.sv
// Load/store unit: turns one execute-stage memory op into a word-aligned
// req/gnt/rvalid bus transaction and returns the aligned, extended load data.
module lsu_mem_if #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        req_ready_o,
    output logic        stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic [31:0] mem_o,
    output logic        done_o,
    output logic        misalign_o,
    output logic        err_o
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [2:0]        funct3_q;
    logic [1:0]        off_q;
    logic [CNT_W-1:0]  cnt;

    logic [1:0]        off;
    logic              is_half;
    logic              is_word;
    logic              misaligned;
    logic              illegal;
    logic              start;
    logic              accept;
    logic              timeout;
    logic [3:0]        be_nxt;
    logic [31:0]       wdata_nxt;
    logic [31:0]       lane;
    logic [31:0]       load_ext;

    // Request decode: legality, alignment, byte enables and lane-replicated store data.
    always_comb begin
        off        = req_addr_i[1:0];
        is_half    = (req_funct3_i[1:0] == 2'b01);
        is_word    = (req_funct3_i == 3'b010);
        misaligned = (is_half && off[0]) || (is_word && (off != 2'b00));
        if (req_we_i)
            illegal = !(req_funct3_i == 3'b000 || req_funct3_i == 3'b001 || req_funct3_i == 3'b010);
        else
            illegal = (req_funct3_i == 3'b011) || (req_funct3_i[2:1] == 2'b11);
        start  = req_valid_i && (state == IDLE);
        accept = start && !illegal && !misaligned;

        be_nxt    = 4'b1111;
        wdata_nxt = 32'h0;
        case (req_funct3_i[1:0])
            2'b00: be_nxt = 4'b0001 << off;
            2'b01: be_nxt = 4'b0011 << off;
            default: be_nxt = 4'b1111;
        endcase
        if (req_we_i) begin
            case (req_funct3_i[1:0])
                2'b00: wdata_nxt = {4{req_wdata_i[7:0]}};
                2'b01: wdata_nxt = {2{req_wdata_i[15:0]}};
                default: wdata_nxt = req_wdata_i;
            endcase
        end
    end

    // Load data alignment and sign/zero extension of the selected lane.
    always_comb begin
        lane     = mem_rdata_i >> {off_q, 3'b000};
        load_ext = lane;
        case (funct3_q)
            3'b000: load_ext = {{24{lane[7]}}, lane[7:0]};
            3'b001: load_ext = {{16{lane[15]}}, lane[15:0]};
            3'b100: load_ext = {24'h0, lane[7:0]};
            3'b101: load_ext = {16'h0, lane[15:0]};
            default: load_ext = lane;
        endcase
        timeout = (cnt == CNT_W'(TIMEOUT - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // A response in the final timeout cycle still completes normally.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = REQ;
            REQ:  if (mem_gnt_i) state_nxt = WAIT;
            WAIT: if (mem_rvalid_i || timeout) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = (state == IDLE);
        mem_req_o   = (state == REQ);
        stall_o     = (state != IDLE) || accept;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            funct3_q    <= 3'b000;
            off_q       <= 2'b00;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= 32'h0;
            mem_be_o    <= 4'h0;
            mem_wdata_o <= 32'h0;
            cnt         <= '0;
            mem_o       <= 32'h0;
            done_o      <= 1'b0;
            misalign_o  <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            done_o     <= (state == WAIT) && mem_rvalid_i;
            err_o      <= (start && illegal) || ((state == WAIT) && !mem_rvalid_i && timeout);
            misalign_o <= start && !illegal && misaligned;
            if (accept) begin
                funct3_q    <= req_funct3_i;
                off_q       <= off;
                mem_we_o    <= req_we_i;
                mem_addr_o  <= {req_addr_i[31:2], 2'b00};
                mem_be_o    <= be_nxt;
                mem_wdata_o <= wdata_nxt;
            end
            if ((state == REQ) && mem_gnt_i)
                cnt <= '0;
            else if (state == WAIT)
                cnt <= cnt + 1'b1;
            if ((state == WAIT) && mem_rvalid_i && !mem_we_o)
                mem_o <= load_ext;
        end
    end

endmodule

// File: tb/tb_lsu_mem_if.sv
// Directed bench for lsu_mem_if: loads, stores, rejects, timeout and async reset,
// built with a short timeout so the expiry paths are reachable quickly.
module tb_lsu_mem_if;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i;
    logic        req_we_i;
    logic [2:0]  req_funct3_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        req_ready_o;
    logic        stall_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic [31:0] mem_o;
    logic        done_o;
    logic        misalign_o;
    logic        err_o;

    int total = 0;
    int bad   = 0;

    lsu_mem_if #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_we_i(req_we_i), .req_funct3_i(req_funct3_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .req_ready_o(req_ready_o), .stall_o(stall_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .mem_o(mem_o), .done_o(done_o), .misalign_o(misalign_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One full operation: accept, REQ for gnt_delay+1 cycles, WAIT for rv_delay+1 cycles, done.
    task automatic applyStimulus(input string tag, input logic we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] rdata, input int gnt_delay, input int rv_delay,
                                 input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                                 input logic [31:0] exp_memo);
        req_valid_i  = 1'b1;
        req_we_i     = we;
        req_funct3_i = f3;
        req_addr_i   = addr;
        req_wdata_i  = wdata;
        #1;
        checkOutput({tag, ".accept_stall"}, 32'(stall_o), 32'd1);
        checkOutput({tag, ".accept_ready"}, 32'(req_ready_o), 32'd1);
        tick();
        req_valid_i = 1'b0;
        for (int i = 0; i <= gnt_delay; i++) begin
            mem_gnt_i = (i == gnt_delay);
            #1;
            checkOutput({tag, ".req"}, 32'(mem_req_o), 32'd1);
            checkOutput({tag, ".req_stall"}, 32'(stall_o), 32'd1);
            checkOutput({tag, ".ready"}, 32'(req_ready_o), 32'd0);
            checkOutput({tag, ".we"}, 32'(mem_we_o), 32'(we));
            checkOutput({tag, ".addr"}, mem_addr_o, addr & 32'hFFFF_FFFC);
            checkOutput({tag, ".be"}, 32'(mem_be_o), 32'(exp_be));
            checkOutput({tag, ".wdata"}, mem_wdata_o, exp_wdata);
            tick();
        end
        mem_gnt_i = 1'b0;
        for (int i = 0; i < rv_delay; i++) begin
            #1;
            checkOutput({tag, ".wait_req"}, 32'(mem_req_o), 32'd0);
            checkOutput({tag, ".wait_stall"}, 32'(stall_o), 32'd1);
            tick();
        end
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = rdata;
        #1;
        checkOutput({tag, ".wait_req"}, 32'(mem_req_o), 32'd0);
        checkOutput({tag, ".wait_stall"}, 32'(stall_o), 32'd1);
        tick();
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'h0;
        #1;
        checkOutput({tag, ".done"}, 32'(done_o), 32'd1);
        checkOutput({tag, ".no_err"}, 32'(err_o), 32'd0);
        checkOutput({tag, ".mem_o"}, mem_o, exp_memo);
        checkOutput({tag, ".idle_stall"}, 32'(stall_o), 32'd0);
        checkOutput({tag, ".idle_ready"}, 32'(req_ready_o), 32'd1);
        tick();
        checkOutput({tag, ".done_pulse"}, 32'(done_o), 32'd0);
    endtask

    initial begin
        rst          = 1'b1;
        req_valid_i  = 1'b0;
        req_we_i     = 1'b0;
        req_funct3_i = 3'b000;
        req_addr_i   = 32'h0;
        req_wdata_i  = 32'h0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'h0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        $display("[TB] reset state");
        checkOutput("rst.ready", 32'(req_ready_o), 32'd1);
        checkOutput("rst.stall", 32'(stall_o), 32'd0);
        checkOutput("rst.req", 32'(mem_req_o), 32'd0);
        checkOutput("rst.mem_o", mem_o, 32'h0);
        checkOutput("rst.flags", {29'h0, done_o, misalign_o, err_o}, 32'h0);
        checkOutput("rst.addr", mem_addr_o, 32'h0);

        $display("[TB] loads and store");
        applyStimulus("lb", 1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_FF7F, 0, 0,
                      4'b1000, 32'h0, 32'hFFFF_FF80);
        applyStimulus("lhu", 1'b0, 3'b101, 32'h0000_2002, 32'h0, 32'hBEEF_1234, 0, 0,
                      4'b1100, 32'h0, 32'h0000_BEEF);
        applyStimulus("lh", 1'b0, 3'b001, 32'h0000_2002, 32'h0, 32'hBEEF_1234, 0, 1,
                      4'b1100, 32'h0, 32'hFFFF_BEEF);
        applyStimulus("sh", 1'b1, 3'b001, 32'h0000_3002, 32'h1234_ABCD, 32'h5555_5555, 3, 0,
                      4'b1100, 32'hABCD_ABCD, 32'hFFFF_BEEF);
        applyStimulus("sb", 1'b1, 3'b000, 32'h0000_3001, 32'h0000_00A5, 32'h0, 0, 0,
                      4'b0010, 32'hA5A5_A5A5, 32'hFFFF_BEEF);
        applyStimulus("lbu", 1'b0, 3'b100, 32'h0000_3001, 32'h0, 32'h1122_C344, 1, 0,
                      4'b0010, 32'h0, 32'h0000_00C3);

        $display("[TB] rejected requests");
        req_valid_i  = 1'b1;
        req_we_i     = 1'b0;
        req_funct3_i = 3'b010;
        req_addr_i   = 32'h0000_4001;
        #1;
        checkOutput("mis.stall", 32'(stall_o), 32'd0);
        tick();
        req_valid_i = 1'b0;
        checkOutput("mis.pulse", 32'(misalign_o), 32'd1);
        checkOutput("mis.err", 32'(err_o), 32'd0);
        checkOutput("mis.req", 32'(mem_req_o), 32'd0);
        checkOutput("mis.ready", 32'(req_ready_o), 32'd1);
        tick();
        checkOutput("mis.once", 32'(misalign_o), 32'd0);
        checkOutput("mis.req2", 32'(mem_req_o), 32'd0);

        req_valid_i  = 1'b1;
        req_funct3_i = 3'b011;
        req_addr_i   = 32'h0000_4000;
        #1;
        checkOutput("ill.stall", 32'(stall_o), 32'd0);
        tick();
        req_valid_i = 1'b0;
        checkOutput("ill.err", 32'(err_o), 32'd1);
        checkOutput("ill.mis", 32'(misalign_o), 32'd0);
        checkOutput("ill.req", 32'(mem_req_o), 32'd0);
        tick();
        checkOutput("ill.once", 32'(err_o), 32'd0);

        req_valid_i  = 1'b1;
        req_we_i     = 1'b1;
        req_funct3_i = 3'b101;
        req_addr_i   = 32'h0000_4001;
        tick();
        req_valid_i = 1'b0;
        req_we_i    = 1'b0;
        checkOutput("prio.err", 32'(err_o), 32'd1);
        checkOutput("prio.mis", 32'(misalign_o), 32'd0);
        checkOutput("prio.req", 32'(mem_req_o), 32'd0);
        tick();

        $display("[TB] timeout");
        req_valid_i  = 1'b1;
        req_funct3_i = 3'b010;
        req_addr_i   = 32'h0000_5000;
        tick();
        req_valid_i = 1'b0;
        mem_gnt_i   = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("to.early_err", 32'(err_o), 32'd0);
            checkOutput("to.stall", 32'(stall_o), 32'd1);
        end
        tick();
        checkOutput("to.err", 32'(err_o), 32'd1);
        checkOutput("to.done", 32'(done_o), 32'd0);
        checkOutput("to.ready", 32'(req_ready_o), 32'd1);
        checkOutput("to.mem_o", mem_o, 32'h0000_00C3);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hDEAD_BEEF;
        tick();
        mem_rvalid_i = 1'b0;
        checkOutput("late.done", 32'(done_o), 32'd0);
        checkOutput("late.err", 32'(err_o), 32'd0);
        checkOutput("late.mem_o", mem_o, 32'h0000_00C3);

        applyStimulus("lw_last", 1'b0, 3'b010, 32'h0000_5000, 32'h0, 32'hCAFE_F00D, 0, 3,
                      4'b1111, 32'h0, 32'hCAFE_F00D);

        $display("[TB] async reset mid-request");
        req_valid_i  = 1'b1;
        req_funct3_i = 3'b000;
        req_addr_i   = 32'h0000_6000;
        tick();
        req_valid_i = 1'b0;
        checkOutput("ar.req_before", 32'(mem_req_o), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("ar.req_drop", 32'(mem_req_o), 32'd0);
        checkOutput("ar.mem_o", mem_o, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        checkOutput("ar.ready", 32'(req_ready_o), 32'd1);
        checkOutput("ar.req_after", 32'(mem_req_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
